// File: rtl/font_loader.sv
// Copies NWORDS words from the font staging buffer into character-generator SPRAM under req/gnt.
// Optional FONT_LOADER_CHECKSUM_EN adds a running 16-bit sum of written words on checksum_o.
module font_loader #(
    parameter int unsigned BUF_AW   = 8,
    parameter int unsigned SPRAM_AW = 14,
    parameter int unsigned NWORDS   = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [SPRAM_AW-1:0] base_addr_i,
    output logic                buf_rd_o,
    output logic [BUF_AW-1:0]   buf_rd_addr_o,
    input  logic [15:0]         buf_rd_data_i,
    output logic                spram_req_o,
    input  logic                spram_gnt_i,
    output logic                spram_we_o,
    output logic [SPRAM_AW-1:0] spram_addr_o,
    output logic [15:0]         spram_wdata_o,
    output logic                busy_o,
    output logic                done_o
`ifdef FONT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]         checksum_o
`endif
);

    localparam int unsigned IdxW = BUF_AW + 1;
    localparam logic [IdxW-1:0] NWordsL = IdxW'(NWORDS);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StArb, StXfer, StFin} state_e;

    state_e              state_q;
    logic [SPRAM_AW-1:0] base_q;
    logic [IdxW-1:0]     rd_idx_q;
    logic [IdxW-1:0]     wr_idx_q;
    logic                pending_q;
    logic                req_q;
    logic                busy_q;
    logic                done_q;

    logic active;
    logic rd_fire;
    logic wr_fire;
    logic last_wr;

    // Read/write strobes stay combinational on gnt so a dropped grant blocks them the same cycle.
    always_comb begin
        active  = ((state_q == StArb) || (state_q == StXfer)) && spram_gnt_i;
        rd_fire = active && (rd_idx_q < NWordsL);
        wr_fire = active && pending_q;
        last_wr = wr_fire && (wr_idx_q == LastIdx);

        buf_rd_o      = rd_fire;
        buf_rd_addr_o = rd_idx_q[BUF_AW-1:0];
        spram_we_o    = wr_fire;
        spram_addr_o  = base_q + SPRAM_AW'(wr_idx_q);
        spram_wdata_o = buf_rd_data_i;
        spram_req_o   = req_q;
        busy_o        = busy_q;
        done_o        = done_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            base_q    <= '0;
            rd_idx_q  <= '0;
            wr_idx_q  <= '0;
            pending_q <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        base_q    <= base_addr_i;
                        rd_idx_q  <= '0;
                        wr_idx_q  <= '0;
                        pending_q <= 1'b0;
                        req_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= StArb;
                    end
                end
                StArb: begin
                    if (spram_gnt_i) state_q <= StXfer;
                end
                StXfer: begin
                    if (last_wr) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Buffer data holds while ungranted, so frozen pending needs no re-read on regrant.
            if (active)  pending_q <= rd_fire;
            if (rd_fire) rd_idx_q  <= rd_idx_q + IdxW'(1);
            if (wr_fire) wr_idx_q  <= wr_idx_q + IdxW'(1);
        end
    end

`ifdef FONT_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if ((state_q == StIdle) && start_i) begin
            checksum_q <= '0;
        end else if (wr_fire) begin
            checksum_q <= checksum_q + buf_rd_data_i;
        end
    end

    always_comb checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_font_loader.sv
// Self-checking bench for font_loader: staging-buffer and SPRAM models, directed plus random loads.
// Checksum checks are compiled in only when FONT_LOADER_CHECKSUM_EN is defined.
module tb_font_loader;

    localparam int N = 256;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic        buf_rd;
    logic [7:0]  buf_rd_addr;
    logic [15:0] buf_rd_data;
    logic        spram_req;
    logic        spram_gnt;
    logic        spram_we;
    logic [13:0] spram_addr;
    logic [15:0] spram_wdata;
    logic        busy;
    logic        done;
`ifdef FONT_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    font_loader #(
        .BUF_AW  (8),
        .SPRAM_AW(14),
        .NWORDS  (N)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_addr_i  (base_addr),
        .buf_rd_o     (buf_rd),
        .buf_rd_addr_o(buf_rd_addr),
        .buf_rd_data_i(buf_rd_data),
        .spram_req_o  (spram_req),
        .spram_gnt_i  (spram_gnt),
        .spram_we_o   (spram_we),
        .spram_addr_o (spram_addr),
        .spram_wdata_o(spram_wdata),
        .busy_o       (busy),
        .done_o       (done)
`ifdef FONT_LOADER_CHECKSUM_EN
        ,
        .checksum_o   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nchk;
    int          nerr;
    logic [15:0] mem   [N];
    logic [15:0] spram [16384];
    logic [13:0] cur_base;
    int          wr_cnt;
    int          rd_cnt;
    logic        s_busy, s_done, s_req;
    logic [15:0] s_cs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        nchk++;
        assert (obs === exp_v)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle: gnt applied, outputs checked at negedge, buffer read data updated after posedge.
    task automatic step(input logic g);
        logic       rd_pend;
        logic [7:0] rd_a;
        spram_gnt = g;
        @(negedge clk);
        chk("we_without_gnt", spram_we & ~spram_gnt, 1'b0);
        chk("rd_outside_busy", buf_rd & ~busy, 1'b0);
        if (buf_rd) begin
            chk("rd_addr", buf_rd_addr, rd_cnt);
            rd_cnt++;
        end
        if (spram_we) begin
            chk("wr_addr", spram_addr, (int'(cur_base) + wr_cnt) % 16384);
            chk("wr_data", spram_wdata, (wr_cnt < N) ? mem[wr_cnt] : 16'hxxxx);
            spram[spram_addr] = spram_wdata;
            wr_cnt++;
        end
        s_busy = busy;
        s_done = done;
        s_req  = spram_req;
`ifdef FONT_LOADER_CHECKSUM_EN
        s_cs = checksum;
`else
        s_cs = 16'h0;
`endif
        rd_pend = buf_rd;
        rd_a    = buf_rd_addr;
        @(posedge clk);
        #1;
        if (rd_pend) buf_rd_data = mem[rd_a];
    endtask

    // mode 0: gnt held high; 1: drops at words 17 (5 cycles) and 200 (1 cycle); 2: random gnt.
    task automatic do_load(input logic [13:0] base, input int mode, input bit restart,
                           input bit abort, output int done_cyc);
        int          gcnt, exp_done, drop_left;
        bit          d1, d2, r, seen, aborted;
        logic        g;
        logic [15:0] cs;
        cur_base  = base;
        wr_cnt    = 0;
        rd_cnt    = 0;
        gcnt      = 0;
        exp_done  = -1;
        drop_left = 0;
        d1 = 0; d2 = 0; r = 0; seen = 0; aborted = 0;
        done_cyc  = -1;
        cs        = 16'h0;
        for (int i = 0; i < 16384; i++) spram[i] = 16'h0;
        for (int i = 0; i < N; i++) cs = cs + mem[i];

        start     = 1'b1;
        base_addr = base;
        step(1'b1);
        chk("busy_start_cycle", s_busy, 1'b0);
        start     = 1'b0;
        base_addr = 14'($urandom);

        for (int cyc = 1; cyc < 3000 && !seen && !aborted; cyc++) begin
            g = 1'b1;
            if (mode == 1) begin
                if (!d1 && wr_cnt == 17) begin drop_left = 5; d1 = 1; end
                if (!d2 && wr_cnt == 200) begin drop_left = 1; d2 = 1; end
                g = (drop_left == 0);
                if (drop_left > 0) drop_left--;
            end else if (mode == 2) begin
                g = ($urandom_range(0, 3) != 0);
            end
            if (restart && !r && wr_cnt == 50) begin
                start     = 1'b1;
                base_addr = 14'h2000;
                r         = 1;
            end else begin
                start = 1'b0;
            end
            if (abort && wr_cnt == 100) begin
                spram_gnt = 1'b1;
                rst_n     = 1'b0;
                #1;
                chk("abort_req", spram_req, 1'b0);
                chk("abort_we", spram_we, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_rd", buf_rd, 1'b0);
                @(posedge clk);
                #1;
                rst_n   = 1'b1;
                aborted = 1;
            end else begin
                if (g) begin
                    gcnt++;
                    if (gcnt == N + 1) exp_done = cyc + 1;
                end
                step(g);
                chk("busy", s_busy, (exp_done < 0) || (cyc <= exp_done));
                chk("req", s_req, (exp_done < 0) || (cyc < exp_done));
                chk("done", s_done, cyc == exp_done);
                if (s_done) begin
                    seen     = 1;
                    done_cyc = cyc;
`ifdef FONT_LOADER_CHECKSUM_EN
                    chk("checksum_at_done", s_cs, cs);
`endif
                end
            end
        end
        start = 1'b0;

        if (!aborted) begin
            chk("done_seen", seen, 1'b1);
            step(1'b1);
            chk("busy_after_done", s_busy, 1'b0);
            chk("done_one_cycle", s_done, 1'b0);
            chk("write_count", wr_cnt, N);
`ifdef FONT_LOADER_CHECKSUM_EN
            chk("checksum_stable", s_cs, cs);
`endif
            for (int i = 0; i < N; i++)
                chk("spram_content", spram[(int'(base) + i) % 16384], mem[i]);
        end
    endtask

    initial begin
        int dc;
        nchk        = 0;
        nerr        = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = 14'h0;
        spram_gnt   = 1'b0;
        buf_rd_data = 16'h0;
        for (int i = 0; i < N; i++) mem[i] = 16'(i * 3);

        // Reset state, with start and gnt active to show they are ignored under reset.
        start     = 1'b1;
        spram_gnt = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", spram_req, 1'b0);
        chk("rst_we", spram_we, 1'b0);
        chk("rst_rd", buf_rd, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rd_addr", buf_rd_addr, 8'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) step(1'b1);

        do_load(14'h0100, 0, 0, 0, dc);
        chk("t1_done_cycle", dc, 258);

        do_load(14'h0100, 1, 0, 0, dc);
        chk("t2_done_cycle", dc, 264);

        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        do_load(14'h3FF0, 0, 0, 0, dc);
        chk("t3_wrap_word16", spram[0], mem[16]);
        chk("t3_wrap_last", spram[14'h00EF], mem[255]);
        chk("t3_top_word15", spram[14'h3FFF], mem[15]);

        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        do_load(14'h0A00, 2, 1, 0, dc);

        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        do_load(14'h1234, 0, 0, 1, dc);
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        do_load(14'($urandom), 2, 0, 0, dc);

        for (int i = 0; i < N; i++) mem[i] = 16'hFFFF;
        do_load(14'h0000, 0, 0, 0, dc);
`ifdef FONT_LOADER_CHECKSUM_EN
        chk("t6_checksum", s_cs, 16'hFF00);
`endif

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
            do_load(14'($urandom), 2, 0, 0, dc);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
